// File: rtl/board_engine.sv
`default_nettype none
// ============================================================================
// Module   : board_engine
// Purpose  : Parametrised Connect-4 game core. Holds a ROWS x COLS board of
//            2-bit cells, accepts column drops over a valid/ready handshake,
//            rejects full or out-of-range columns, and walks outward from the
//            placed cell in four directions, one cell per cycle, to detect a
//            WIN_LEN line or a draw.
// Ports    : CLOCK_50     - system clock, rising edge
//            resetn       - asynchronous active-low reset
//            start_game   - new-game clear (honoured in IDLE/OVER only)
//            drop_valid   - drop request
//            drop_col     - target column
//            drop_ready   - engine can accept a drop
//            result_valid - one-cycle pulse qualifying result_code
//            result_code  - 00 accepted, 01 rejected, 10 win, 11 draw
//            turn         - player to move (01 = P1, 10 = P2)
//            winner       - 00 none, else winning player code
//            game_over    - win or draw reached
//            board        - cell (r,c) at bits [2(r*COLS+c)+1 : 2(r*COLS+c)]
// Revision : 1.0 - initial release
// ============================================================================
module board_engine #(
    parameter int  ROWS    = 6,
    parameter int  COLS    = 7,
    parameter int  WIN_LEN = 4,
    localparam int COL_W   = $clog2(COLS)
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     start_game,
    input  logic                     drop_valid,
    input  logic [COL_W-1:0]         drop_col,
    output logic                     drop_ready,
    output logic                     result_valid,
    output logic [1:0]               result_code,
    output logic [1:0]               turn,
    output logic [1:0]               winner,
    output logic                     game_over,
    output logic [2*ROWS*COLS-1:0]   board
);

    localparam int CELLS = ROWS * COLS;
    localparam int H_W   = $clog2(ROWS + 1);
    localparam int M_W   = $clog2(CELLS + 1);
    localparam int K_W   = $clog2(WIN_LEN);
    localparam int RUN_W = $clog2(WIN_LEN + 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PLACE  = 3'd1;
    localparam logic [2:0] c_ST_SCAN   = 3'd2;
    localparam logic [2:0] c_ST_REPORT = 3'd3;
    localparam logic [2:0] c_ST_OVER   = 3'd4;

    localparam logic [1:0] c_P1 = 2'b01;

    logic [2:0]                 r_state, w_next;
    logic [2*CELLS-1:0]         r_board, w_board_next;
    logic [COLS-1:0][H_W-1:0]   r_height;
    logic [M_W-1:0]             r_moves;
    logic [1:0]                 r_turn, r_winner, r_piece;
    logic                       r_game_over;
    logic [H_W-1:0]             r_r0;
    logic [COL_W-1:0]           r_c0;
    logic                       r_reject, r_win, r_broken, r_side;
    logic [1:0]                 r_dir;
    logic [K_W-1:0]             r_k;
    logic [RUN_W-1:0]           r_run, w_run_next;

    logic                       w_clear, w_drop_oob, w_reject, w_full;
    logic                       w_match, w_step_ok, w_side_end, w_scan_end;
    logic [CELLS-1:0]           w_hit, w_wr_sel;
    int                         w_dr, w_dc, w_row, w_col;

    // start_game only takes effect while no move is in flight
    assign w_clear    = start_game && (r_state == c_ST_IDLE || r_state == c_ST_OVER);
    assign w_drop_oob = (int'(drop_col) >= COLS);
    // the height read is don't-care when the column is out of range
    assign w_reject   = w_drop_oob || (r_height[drop_col] == H_W'(ROWS));
    assign w_full     = (r_moves == M_W'(CELLS));

    // ------------------------------------------------------------------
    // Walker address: placed cell plus k steps along the current direction,
    // negated on the second side. Signed ints keep off-board cells distinct
    // so nothing wraps between rows or columns.
    // ------------------------------------------------------------------
    always_comb begin
        w_dr = 0;
        w_dc = 1;
        case (r_dir)
            2'd0:    begin w_dr = 0; w_dc = 1;  end
            2'd1:    begin w_dr = 1; w_dc = 0;  end
            2'd2:    begin w_dr = 1; w_dc = 1;  end
            default: begin w_dr = 1; w_dc = -1; end
        endcase
        w_row = int'(r_r0) + (r_side ? -w_dr : w_dr) * int'(r_k);
        w_col = int'(r_c0) + (r_side ? -w_dc : w_dc) * int'(r_k);
    end

    genvar gr, gc;
    generate
        for (gr = 0; gr < ROWS; gr = gr + 1) begin : g_row
            for (gc = 0; gc < COLS; gc = gc + 1) begin : g_col
                localparam int c_IDX = gr * COLS + gc;
                // an off-board walker address matches no cell
                assign w_hit[c_IDX]    = (w_row == gr) && (w_col == gc) &&
                                         (r_board[2*c_IDX +: 2] == r_piece);
                assign w_wr_sel[c_IDX] = (int'(r_r0) == gr) && (int'(r_c0) == gc);
                assign w_board_next[2*c_IDX +: 2] =
                    w_wr_sel[c_IDX] ? r_piece : r_board[2*c_IDX +: 2];
            end
        end
    endgenerate

    assign w_match    = |w_hit;
    assign w_step_ok  = !r_broken && w_match;
    assign w_run_next = (w_step_ok && (r_run != RUN_W'(WIN_LEN))) ? r_run + 1'b1 : r_run;
    assign w_side_end = (r_k == K_W'(WIN_LEN - 1));
    assign w_scan_end = (r_dir == 2'd3) && r_side && w_side_end;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (!start_game && drop_valid)
                             w_next = w_reject ? c_ST_REPORT : c_ST_PLACE;
            c_ST_PLACE:  w_next = c_ST_SCAN;
            c_ST_SCAN:   if (w_scan_end) w_next = c_ST_REPORT;
            c_ST_REPORT: w_next = (!r_reject && (r_win || w_full)) ? c_ST_OVER : c_ST_IDLE;
            c_ST_OVER:   if (start_game) w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. winner/game_over are already valid during the result
    // pulse; the registered copies take over from the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        drop_ready   = (r_state == c_ST_IDLE);
        result_valid = (r_state == c_ST_REPORT);
        result_code  = 2'b00;
        winner       = r_winner;
        game_over    = r_game_over;
        if (r_state == c_ST_REPORT) begin
            if (r_reject) begin
                result_code = 2'b01;
            end else if (r_win) begin
                result_code = 2'b10;
                winner      = r_piece;
                game_over   = 1'b1;
            end else if (w_full) begin
                result_code = 2'b11;
                game_over   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: board, heights, move count, walker state
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_board     <= '0;
            r_height    <= '0;
            r_moves     <= '0;
            r_turn      <= c_P1;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
            r_piece     <= 2'b00;
            r_r0        <= '0;
            r_c0        <= '0;
            r_reject    <= 1'b0;
            r_win       <= 1'b0;
            r_broken    <= 1'b0;
            r_side      <= 1'b0;
            r_dir       <= 2'd0;
            r_k         <= K_W'(1);
            r_run       <= RUN_W'(1);
        end else if (w_clear) begin
            r_board     <= '0;
            r_height    <= '0;
            r_moves     <= '0;
            r_turn      <= c_P1;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (drop_valid) begin
                        r_reject <= w_reject;
                        r_r0     <= r_height[drop_col];
                        r_c0     <= drop_col;
                        r_piece  <= r_turn;
                        r_win    <= 1'b0;
                        r_broken <= 1'b0;
                        r_side   <= 1'b0;
                        r_dir    <= 2'd0;
                        r_k      <= K_W'(1);
                        r_run    <= RUN_W'(1);
                    end
                end
                c_ST_PLACE: begin
                    r_board          <= w_board_next;
                    r_height[r_c0]   <= r_height[r_c0] + 1'b1;
                    r_moves          <= r_moves + 1'b1;
                end
                c_ST_SCAN: begin
                    r_run <= w_run_next;
                    if (w_run_next == RUN_W'(WIN_LEN)) r_win <= 1'b1;
                    if (w_side_end) begin
                        r_k      <= K_W'(1);
                        r_broken <= 1'b0;
                        if (r_side) begin
                            // both sides done: next direction starts afresh
                            r_side <= 1'b0;
                            r_run  <= RUN_W'(1);
                            r_dir  <= r_dir + 1'b1;
                        end else begin
                            r_side <= 1'b1;
                        end
                    end else begin
                        r_k      <= r_k + 1'b1;
                        r_broken <= !w_step_ok;
                    end
                end
                c_ST_REPORT: begin
                    if (!r_reject) begin
                        if (r_win) begin
                            r_winner    <= r_piece;
                            r_game_over <= 1'b1;
                        end else if (w_full) begin
                            r_game_over <= 1'b1;
                        end else begin
                            r_turn <= ~r_turn;   // 01 <-> 10
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign turn  = r_turn;
    assign board = r_board;

endmodule
`default_nettype wire

// File: doc/board_engine.md
# board_engine

Parametrised Connect-4 game core: holds a ROWS×COLS board of 2-bit cells, accepts column drops through a valid/ready handshake, rejects full or out-of-range columns, and scans from the placed cell in all four directions with a sequential walker to detect a WIN_LEN line or a draw. It sits between the input front end (switches/keyboard) and the display/winner logic. It replaces the fixed 7×7 combinational board with a clocked, generic-size engine.

## Interface

- ROWS, default 6: board rows; row 0 is the bottom.
- COLS, default 7: board columns. COL_W = clog2(COLS) is a local parameter.
- WIN_LEN, default 4: run length that wins; must satisfy 2 ≤ WIN_LEN ≤ max(ROWS, COLS).

Ports:

- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_game  in  1  synchronous new-game clear.
- drop_valid  in  1  drop request.
- drop_col  in  COL_W  target column.
- drop_ready  out  1  engine can accept a drop.
- result_valid  out  1  one-cycle pulse carrying result_code.
- result_code  out  2  00 accepted, 01 rejected, 10 win, 11 draw.
- turn  out  2  player to move: 01 = P1, 10 = P2.
- winner  out  2  00 = none, else the winning player code.
- game_over  out  1  win or draw reached.
- board  out  2*ROWS*COLS  cell (r,c) at bits [2(r·COLS+c)+1 : 2(r·COLS+c)]; 00 = empty.

## Operation

- **Per-column state.** The engine keeps a height counter per column, width clog2(ROWS+1). It also keeps a move counter of width clog2(ROWS·COLS+1).
- **States.** The state machine has five states: IDLE, PLACE, SCAN, REPORT, OVER.
- **IDLE.**
  - drop_ready = 1.
  - On drop_valid with start_game = 0:
    - If drop_col ≥ COLS or height[drop_col] == ROWS: latch code 01 and go to REPORT.
    - Otherwise: latch r0 = height[drop_col], c0 = drop_col, piece = turn, and go to PLACE.
- **PLACE.**
  - Write cell (r0,c0) = piece.
  - Increment height[c0] and the move counter.
  - Go to SCAN.
- **SCAN.**
  - Directions are processed in the fixed order: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,−1).
  - Each direction starts with run = 1. The walker scans the positive side, then the negative side.
  - Each side takes exactly WIN_LEN−1 steps, one cell per cycle, at offsets k = 1..WIN_LEN−1.
  - A step increments run only if the cell is in bounds, the side is not yet broken, and the cell equals piece. Otherwise the side is marked broken.
  - Bounds are checked per coordinate, with no wrap between rows or columns.
  - run saturates at WIN_LEN. If run reaches WIN_LEN in any direction, the win flag is set.
  - There is no early exit: SCAN always lasts 8·(WIN_LEN−1) cycles, then goes to REPORT.
- **REPORT.** result_valid = 1 for one cycle, then:
  - win: code 10, winner = piece, game_over = 1, go to OVER.
  - else if move counter == ROWS·COLS: code 11, winner = 00, game_over = 1, go to OVER.
  - else if the drop was accepted: code 00, turn toggles (01↔10), go to IDLE.
  - rejected: code 01, turn and board unchanged, go to IDLE.
- **OVER.** drop_ready = 0. drop_valid is ignored and produces no result.
- **start_game.**
  - Honoured only in IDLE or OVER. It clears the board, heights and move counter, and sets turn = 01, winner = 00, game_over = 0, state IDLE.
  - Ignored in PLACE, SCAN and REPORT.
  - If start_game and drop_valid are both high in IDLE, start_game wins and the drop is discarded.
- **Reset.**
  - resetn low forces the state IDLE and clears everything: board = 0, heights = 0, turn = 01, winner = 00, game_over = 0, result_valid = 0, result_code = 00, drop_ready = 1 after release.
  - Reset asserted mid-SCAN aborts the move with no result.

## Timing

- A drop is accepted at edge T, when drop_valid & drop_ready are both high.
- Reject: result_valid is high in the cycle after edge T (latency 1).
- Accept: the board and height update at edge T+1. result_valid is high after edge T+1+8·(WIN_LEN−1), i.e. T+25 at the defaults.
- drop_ready is low from edge T until the return to IDLE.
- result_code and winner are valid while result_valid = 1. winner and game_over hold until start_game or reset.
- board reflects committed state only; it never shows a partial move.

## Test plan

- **Reset values.** Assert resetn = 0 mid-operation, then release → board = 0, turn = 01, winner = 00, game_over = 0, result_valid = 0, drop_ready = 1.
- **Vertical win.** Drop columns 3,4,3,4,3,4,3 → last result: code 10 exactly 25 cycles after acceptance; winner = 01; game_over = 1; drop_ready = 0. A further drop_valid produces no pulse.
- **Full and out-of-range columns.**
  - Six drops into column 0, then a seventh → code 01 one cycle after acceptance; turn and board unchanged.
  - drop_col = 7 → code 01.
- **No row wrap.** P1 occupies row 0 columns 5,6 and row 1 columns 0,1 (P2 filler elsewhere) → all results 00, no win. Then P1 completes row 0 columns 3–6 → code 10, with the anti-diagonal scan exercised at the edge.
- **Draw.** A scripted 42-move fill with no four-in-line → 41 results of 00, then 11 with winner = 00.
- **start_game priority.**
  - start_game pulsed during SCAN → ignored; the move completes normally.
  - start_game and drop_valid both high in IDLE → board cleared, no result pulse.
